// File: rtl/fpmul_issue_ctrl_pkg.sv
// Shared constants for the FP multiplier issue controller: requester id
// encodings and the default pipeline depth per operand width.
package fpmul_issue_ctrl_pkg;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // The multiplier is five stages deep for every supported format.
    function automatic int default_num_stg(input int dw);
        case (dw)
            16:      return 5;
            32:      return 5;
            64:      return 5;
            default: return 5;
        endcase
    endfunction

endpackage

// File: rtl/fpmul_issue_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins, a tie goes to ptr.
module rr_arb2
    import fpmul_issue_ctrl_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    input  logic       en,
    output logic [1:0] gnt,
    output logic       gnt_id,
    output logic       any
);

    always_comb begin
        gnt    = 2'b00;
        gnt_id = REQ0;
        any    = en & (|req);
        if (any) begin
            gnt_id = (req == 2'b11) ? ptr : req[1];
            gnt    = (gnt_id == REQ1) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/fpmul_issue_ctrl.sv
// Issue controller sharing one pipelined FP multiplier between two requesters,
// tracking valid/owner per stage and stalling the pipe on result backpressure.
module fpmul_issue_ctrl
    import fpmul_issue_ctrl_pkg::*;
#(
    parameter int DW      = 16,
    parameter int NUM_STG = default_num_stg(DW),
    parameter int CG_EN   = 0,
    parameter int CNT_W   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [DW-1:0]    req0_a,
    input  logic [DW-1:0]    req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [DW-1:0]    req1_a,
    input  logic [DW-1:0]    req1_b,
    output logic [DW-1:0]    mul_a,
    output logic [DW-1:0]    mul_b,
    output logic             mul_en,
    input  logic [DW-1:0]    mul_res,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_id,
    output logic [DW-1:0]    res_data,
    output logic [CNT_W-1:0] inflight,
    output logic             busy
);

    logic [NUM_STG-1:0] vld_q, vld_d;
    logic [NUM_STG-1:0] tag_q, tag_d;
    logic               rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   inflight_q, inflight_d;

    logic       adv;
    logic       retire;
    logic [1:0] gnt;
    logic       gnt_id;
    logic       any_gnt;

    // With clock-gated stages the multiplier cannot hold, so neither can we.
    assign adv    = (CG_EN != 0) ? 1'b1 : (~vld_q[NUM_STG-1] | res_ready);
    assign retire = vld_q[NUM_STG-1] & adv;

    // Grants are suppressed during reset so no requester sees a spurious ready.
    rr_arb2 u_arb (
        .req    ({req1_valid, req0_valid}),
        .ptr    (rr_ptr_q),
        .en     (adv & ~rst),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .any    (any_gnt)
    );

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        if (gnt[0]) begin
            mul_a = req0_a;
            mul_b = req0_b;
        end else if (gnt[1]) begin
            mul_a = req1_a;
            mul_b = req1_b;
        end
    end

    always_comb begin
        vld_d      = vld_q;
        tag_d      = tag_q;
        rr_ptr_d   = rr_ptr_q;
        inflight_d = inflight_q;
        if (adv) begin
            vld_d = {vld_q[NUM_STG-2:0], any_gnt};
            tag_d = {tag_q[NUM_STG-2:0], gnt_id};
            if (any_gnt)
                rr_ptr_d = ~gnt_id;
        end
        case ({any_gnt, retire})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q      <= '0;
            tag_q      <= '0;
            rr_ptr_q   <= REQ0;
            inflight_q <= '0;
        end else begin
            vld_q      <= vld_d;
            tag_q      <= tag_d;
            rr_ptr_q   <= rr_ptr_d;
            inflight_q <= inflight_d;
        end
    end

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign mul_en     = adv;
    assign res_valid  = vld_q[NUM_STG-1];
    assign res_id     = tag_q[NUM_STG-1];
    assign res_data   = mul_res;
    assign inflight   = inflight_q;
    assign busy       = (inflight_q != '0);

endmodule

// File: tb/tb_fpmul_issue_ctrl.sv
// Directed bench for fpmul_issue_ctrl: stalling build with a behavioural
// multiplier pipe, plus a CG_EN=1 build with a constant multiplier result.
module tb_fpmul_issue_ctrl;

    localparam int DW = 16;
    localparam int NS = 5;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [DW-1:0] mul_a, mul_b, mul_res, res_data;
    logic          mul_en, res_valid, res_ready, res_id, busy;
    logic [CW-1:0] inflight;

    logic          c_req0_valid, c_req0_ready, c_req1_valid, c_req1_ready;
    logic [DW-1:0] c_mul_a, c_mul_b, c_res_data;
    logic          c_mul_en, c_res_valid, c_res_ready, c_res_id, c_busy;
    logic [CW-1:0] c_inflight;

    int checks   = 0;
    int failures = 0;

    fpmul_issue_ctrl #(.DW(DW), .NUM_STG(NS), .CG_EN(0), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_en(mul_en), .mul_res(mul_res),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_data(res_data),
        .inflight(inflight), .busy(busy)
    );

    fpmul_issue_ctrl #(.DW(DW), .NUM_STG(NS), .CG_EN(1), .CNT_W(CW)) dut_cg (
        .clk(clk), .rst(rst),
        .req0_valid(c_req0_valid), .req0_ready(c_req0_ready), .req0_a(16'h1111), .req0_b(16'h2222),
        .req1_valid(c_req1_valid), .req1_ready(c_req1_ready), .req1_a(16'h3333), .req1_b(16'h4444),
        .mul_a(c_mul_a), .mul_b(c_mul_b), .mul_en(c_mul_en), .mul_res(16'hABCD),
        .res_valid(c_res_valid), .res_ready(c_res_ready), .res_id(c_res_id), .res_data(c_res_data),
        .inflight(c_inflight), .busy(c_busy)
    );

    // Stand-in multiplier: exact for the fp16 pairs used, a^b marker otherwise.
    function automatic logic [DW-1:0] fmul(input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (a == 16'h3C00 && b == 16'h4000) return 16'h4000;
        if (a == 16'h4200 && b == 16'h4000) return 16'h4600;
        return a ^ b;
    endfunction

    logic [DW-1:0] pipe [NS];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NS; i++) pipe[i] <= '0;
        end else if (mul_en) begin
            pipe[0] <= fmul(mul_a, mul_b);
            for (int i = 1; i < NS; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign mul_res = pipe[NS-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        res_ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        res_ready = 1'b0;
        c_req0_valid = 1'b0; c_req1_valid = 1'b0; c_res_ready = 1'b0;
        step(); step();

        // reset state, with a request pending that must not be granted
        req0_valid = 1'b1; req0_a = 16'h1234; #1;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_ready0",    req0_ready, 0);
        chk("rst_mul_en",    mul_en, 1);
        chk("rst_mul_a",     mul_a, 0);
        chk("rst_inflight",  inflight, 0);
        chk("rst_busy",      busy, 0);
        req0_valid = 1'b0;
        rst = 1'b0;

        // single op
        req0_valid = 1'b1; req0_a = 16'h3C00; req0_b = 16'h4000; res_ready = 1'b1;
        #3;
        chk("t1_ready0", req0_ready, 1);
        chk("t1_mul_a",  mul_a, 16'h3C00);
        chk("t1_mul_b",  mul_b, 16'h4000);
        step();
        req0_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            #3;
            chk("t1_no_res", res_valid, 0);
            if (c == 1) chk("t1_inflight1", inflight, 1);
            step();
        end
        #3;
        chk("t1_res_valid", res_valid, 1);
        chk("t1_res_data",  res_data, 16'h4000);
        chk("t1_res_id",    res_id, 0);
        step();
        #3;
        chk("t1_inflight0", inflight, 0);
        chk("t1_busy0",     busy, 0);

        // contention: grants must alternate starting from requester 0
        do_reset();
        for (int c = 0; c < 4; c++) begin
            req0_valid = 1'b1; req0_a = 16'h4200; req0_b = 16'h4000;
            req1_valid = 1'b1; req1_a = 16'h3C00; req1_b = 16'h4000;
            res_ready = 1'b1;
            #3;
            chk("ct_ready0", req0_ready, (c % 2 == 0));
            chk("ct_ready1", req1_ready, (c % 2 == 1));
            step();
        end
        idle_inputs();
        #3; chk("ct_gap", res_valid, 0); step();
        for (int c = 5; c <= 8; c++) begin
            #3;
            chk("ct_res_valid", res_valid, 1);
            chk("ct_res_id",    res_id, (c - 5) % 2);
            chk("ct_res_data",  res_data, ((c - 5) % 2) ? 16'h4000 : 16'h4600);
            step();
        end
        #3; chk("ct_idle", busy, 0);

        // backpressure: fill the pipe, hold, then drain
        res_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            req0_valid = 1'b1; req0_a = 16'h0100 + 16'(c); req0_b = 16'h0000;
            #3; chk("bp_fill_ready", req0_ready, 1);
            step();
        end
        for (int c = 5; c <= 7; c++) begin
            req0_a = 16'h0105;
            #3;
            chk("bp_mul_en",   mul_en, 0);
            chk("bp_ready0",   req0_ready, 0);
            chk("bp_valid",    res_valid, 1);
            chk("bp_data",     res_data, 16'h0100);
            chk("bp_inflight", inflight, 5);
            step();
        end
        res_ready = 1'b1;
        #3;
        chk("bp_rel_ready0",   req0_ready, 1);
        chk("bp_rel_data",     res_data, 16'h0100);
        chk("bp_rel_inflight", inflight, 5);
        step();
        req0_valid = 1'b0;
        for (int c = 9; c <= 13; c++) begin
            #3;
            chk("bp_drain_valid", res_valid, 1);
            chk("bp_drain_data",  res_data, 16'h0100 + 16'(c - 8));
            if (c == 9) chk("bp_drain_inflight", inflight, 5);
            step();
        end
        #3;
        chk("bp_empty_valid", res_valid, 0);
        chk("bp_empty_cnt",   inflight, 0);

        // simultaneous accept and retire
        res_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            req0_valid = 1'b1; req0_a = 16'h0200 + 16'(c); req0_b = 16'h0000;
            step();
        end
        req0_valid = 1'b0;
        step(); step();
        #3;
        chk("sim_stall_valid", res_valid, 1);
        chk("sim_stall_en",    mul_en, 0);
        chk("sim_stall_cnt",   inflight, 3);
        step();
        res_ready = 1'b1; req1_valid = 1'b1; req1_a = 16'h0300; req1_b = 16'h0000;
        #3;
        chk("sim_ready1", req1_ready, 1);
        chk("sim_data",   res_data, 16'h0200);
        chk("sim_cnt",    inflight, 3);
        step();
        req1_valid = 1'b0;
        #3;
        chk("sim_cnt_after", inflight, 3);
        chk("sim_next_data", res_data, 16'h0201);

        // reset mid-flight
        do_reset();
        res_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            req0_valid = 1'b1; req0_a = 16'h0400 + 16'(c); req0_b = 16'h0000;
            step();
        end
        req0_valid = 1'b0;
        #1;
        chk("mr_pre_cnt", inflight, 4);
        rst = 1'b1;
        #1;
        chk("mr_vld",       dut.vld_q, 0);
        chk("mr_res_valid", res_valid, 0);
        chk("mr_cnt",       inflight, 0);
        chk("mr_busy",      busy, 0);
        step();
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #3; chk("mr_no_stale", res_valid, 0);
            step();
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #3;
        chk("mr_ptr_ready0", req0_ready, 1);
        chk("mr_ptr_ready1", req1_ready, 0);
        step();
        idle_inputs();

        // CG_EN=1 build ignores res_ready
        c_res_ready = 1'b0;
        c_req0_valid = 1'b1;
        #3; chk("cg_ready0", c_req0_ready, 1);
        step();
        c_req0_valid = 1'b0;
        for (int c = 1; c <= 4; c++) step();
        c_req1_valid = 1'b1;
        #3;
        chk("cg_res_valid", c_res_valid, 1);
        chk("cg_mul_en",    c_mul_en, 1);
        chk("cg_ready1",    c_req1_ready, 1);
        chk("cg_res_data",  c_res_data, 16'hABCD);
        step();
        c_req1_valid = 1'b0;
        #3;
        chk("cg_advanced", c_res_valid, 0);
        chk("cg_inflight", c_inflight, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
